// File: rtl/upc_scan_tally.sv
// upc_scan_tally: saturating item/discount/theft tallies behind the UPC checker, plus a latched, blinking theft alarm.
// Build option STOLEN_LOCK_EN: scans are ignored while the alarm is active.
module upc_scan_tally #(
  parameter int CNT_W     = 4,
  parameter int BLINK_DIV = 25000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scan,
  input  logic             discounted,
  input  logic             stolen,
  input  logic             ack,
  output logic [CNT_W-1:0] item_count,
  output logic [CNT_W-1:0] disc_count,
  output logic [CNT_W-1:0] stolen_count,
  output logic             alarm,
  output logic             alarm_led
);

  localparam int              BW         = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0]   BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  localparam logic [0:0] ST_NORMAL = 1'b0;
  localparam logic [0:0] ST_ALARM  = 1'b1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic [CNT_W-1:0] r_item;
  logic [CNT_W-1:0] r_disc;
  logic [CNT_W-1:0] r_stolen;
  logic [0:0]       r_state;
  logic [BW-1:0]    r_blinkCnt;
  logic             r_phase;

  logic             w_hit;
  logic             w_accept;
  logic             w_theft;
  logic [0:0]       w_stateNext;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // History flops reset high so a key held through reset never looks like a fresh press.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= scan;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_hit = r_sync2 & ~r_prev;

`ifdef STOLEN_LOCK_EN
  assign w_accept = w_hit & (r_state == ST_NORMAL);
`else
  assign w_accept = w_hit;
`endif

  assign w_theft = w_accept & stolen;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_item   <= '0;
      r_disc   <= '0;
      r_stolen <= '0;
    end else if (w_accept) begin
      r_item <= satInc(r_item);
      if (discounted) begin
        r_disc <= satInc(r_disc);
      end
      if (stolen) begin
        r_stolen <= satInc(r_stolen);
      end
    end
  end

  // A new theft outranks an acknowledge arriving on the same edge.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_NORMAL: if (w_theft) w_stateNext = ST_ALARM;
      ST_ALARM:  if (ack && !w_theft) w_stateNext = ST_NORMAL;
      default:   w_stateNext = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_NORMAL;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Phase is held at 0 outside ALARM, so it doubles as the gated LED output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_blinkCnt <= '0;
      r_phase    <= 1'b0;
    end else if (w_stateNext == ST_NORMAL) begin
      r_blinkCnt <= '0;
      r_phase    <= 1'b0;
    end else if (r_state == ST_NORMAL) begin
      r_blinkCnt <= '0;
      r_phase    <= 1'b1;
    end else if (r_blinkCnt == BLINK_LAST) begin
      r_blinkCnt <= '0;
      r_phase    <= ~r_phase;
    end else begin
      r_blinkCnt <= r_blinkCnt + 1'b1;
    end
  end

  assign item_count   = r_item;
  assign disc_count   = r_disc;
  assign stolen_count = r_stolen;
  assign alarm        = r_state[0];
  assign alarm_led    = r_phase;

endmodule
